// File: rtl/cnt_bcd_mod.sv
// Multi-digit BCD modulo counter with up/down count, sync clear and
// validated parallel load. co is combinational so stages can be cascaded.
module cnt_bcd_mod #(
  parameter int DIGITS = 2,
  parameter int MOD    = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ci,
  input  logic                dn,
  input  logic                clr,
  input  logic                ld,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                co,
  output logic                err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int           r;
    b = '0;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  generate
    if (DIGITS < 1 || DIGITS > 4 || MOD < 2 || MOD > 10**DIGITS) begin : g_bad_param
      $error("cnt_bcd_mod: illegal DIGITS=%0d / MOD=%0d", DIGITS, MOD);
    end
  endgenerate

  // When the modulus spans every BCD code, any all-decimal load is in range
  // and the modulus itself cannot be represented, so the upper-bound compare
  // is skipped.
  localparam bit           FULL    = (MOD == 10**DIGITS);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MOD - 1);
  localparam logic [W-1:0] MOD_BCD = FULL ? '0 : to_bcd(MOD);

  logic [W-1:0]      count_q, count_d;
  logic              err_q, err_d;
  logic [W-1:0]      inc_val, dec_val;
  logic [DIGITS-1:0] inc_c, dec_b, dig_ok;
  logic              at_max, at_zero, ld_ok;

  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      assign dig    = count_q[4*gi +: 4];
      assign inc_val[4*gi +: 4] = inc_c[gi] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      assign dec_val[4*gi +: 4] = dec_b[gi] ? ((dig == 4'd0) ? 4'd9 : dig - 4'd1) : dig;
      assign dig_ok[gi] = (d[4*gi +: 4] <= 4'd9);
      if (gi < DIGITS - 1) begin : g_chain
        assign inc_c[gi+1] = inc_c[gi] & (dig == 4'd9);
        assign dec_b[gi+1] = dec_b[gi] & (dig == 4'd0);
      end
    end
  endgenerate

  assign at_max  = (count_q == MAX_BCD);
  assign at_zero = (count_q == '0);
  // With every digit decimal, packed BCD orders the same as its value.
  assign ld_ok   = (&dig_ok) && (FULL || (d < MOD_BCD));

  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (ld) begin
      if (ld_ok) count_d = d;
      else       err_d   = 1'b1;
    end else if (ci) begin
      if (dn) count_d = at_zero ? MAX_BCD : dec_val;
      else    count_d = at_max  ? '0      : inc_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign q   = count_q;
  assign err = err_q;
  assign co  = rst & ci & ~clr & ~ld & (dn ? at_zero : at_max);

endmodule

// File: tb/tb_cnt_bcd_mod.sv
// Bench for cnt_bcd_mod: seconds/hours cascade plus 3-digit and 1-digit
// instances, checked against an integer-valued model of the counter rules.
module tb_cnt_bcd_mod;

  logic clk, rst;
  logic sec_ci, sec_dn, sec_clr, sec_ld; logic [7:0]  sec_d; logic [7:0]  sec_q; logic sec_co, sec_err;
  logic hr_dn, hr_clr, hr_ld;            logic [7:0]  hr_d;  logic [7:0]  hr_q;  logic hr_co, hr_err;
  logic day_ci, day_dn, day_clr, day_ld; logic [11:0] day_d; logic [11:0] day_q; logic day_co, day_err;
  logic one_ci, one_dn, one_clr, one_ld; logic [3:0]  one_d; logic [3:0]  one_q; logic one_co, one_err;

  int checks, errors;
  int sec_m, hr_m, day_m, one_m;
  bit sec_em, hr_em, day_em, one_em;

  cnt_bcd_mod #(.DIGITS(2), .MOD(60)) u_sec (.clk(clk), .rst(rst), .ci(sec_ci), .dn(sec_dn),
    .clr(sec_clr), .ld(sec_ld), .d(sec_d), .q(sec_q), .co(sec_co), .err(sec_err));
  cnt_bcd_mod #(.DIGITS(2), .MOD(24)) u_hr (.clk(clk), .rst(rst), .ci(sec_co), .dn(hr_dn),
    .clr(hr_clr), .ld(hr_ld), .d(hr_d), .q(hr_q), .co(hr_co), .err(hr_err));
  cnt_bcd_mod #(.DIGITS(3), .MOD(365)) u_day (.clk(clk), .rst(rst), .ci(day_ci), .dn(day_dn),
    .clr(day_clr), .ld(day_ld), .d(day_d), .q(day_q), .co(day_co), .err(day_err));
  cnt_bcd_mod #(.DIGITS(1), .MOD(10)) u_one (.clk(clk), .rst(rst), .ci(one_ci), .dn(one_dn),
    .clr(one_clr), .ld(one_ld), .d(one_d), .q(one_q), .co(one_co), .err(one_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] b;
    int r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic bit valid_ld(input logic [15:0] b, input int nd, input int m);
    int v;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    return v < m;
  endfunction

  function automatic int bcd2int(input logic [15:0] b, input int nd);
    int v;
    v = 0;
    for (int i = nd - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic int nxt(input int v, input bit ci, input bit dn, input bit clr, input bit ld,
                             input logic [15:0] d, input int nd, input int m);
    if (clr) return 0;
    if (ld) return valid_ld(d, nd, m) ? bcd2int(d, nd) : v;
    if (ci) return dn ? (v + m - 1) % m : (v + 1) % m;
    return v;
  endfunction

  function automatic bit errn(input bit clr, input bit ld, input logic [15:0] d, input int nd, input int m);
    return !clr && ld && !valid_ld(d, nd, m);
  endfunction

  function automatic bit co_f(input int v, input bit ci, input bit dn, input bit clr, input bit ld,
                              input int m, input bit r);
    return r && ci && !clr && !ld && (dn ? (v == 0) : (v == m - 1));
  endfunction

  // Advance one rising edge and move every model forward with it.
  task automatic tick();
    bit hci, se, he, de, oe;
    int sn, hn, dyn, on;
    hci = co_f(sec_m, sec_ci, sec_dn, sec_clr, sec_ld, 60, rst);
    sn  = nxt(sec_m, sec_ci, sec_dn, sec_clr, sec_ld, {8'h00, sec_d}, 2, 60);
    se  = errn(sec_clr, sec_ld, {8'h00, sec_d}, 2, 60);
    hn  = nxt(hr_m, hci, hr_dn, hr_clr, hr_ld, {8'h00, hr_d}, 2, 24);
    he  = errn(hr_clr, hr_ld, {8'h00, hr_d}, 2, 24);
    dyn = nxt(day_m, day_ci, day_dn, day_clr, day_ld, {4'h0, day_d}, 3, 365);
    de  = errn(day_clr, day_ld, {4'h0, day_d}, 3, 365);
    on  = nxt(one_m, one_ci, one_dn, one_clr, one_ld, {12'h000, one_d}, 1, 10);
    oe  = errn(one_clr, one_ld, {12'h000, one_d}, 1, 10);
    @(posedge clk);
    #1;
    if (rst) begin
      sec_m = sn; sec_em = se; hr_m = hn; hr_em = he;
      day_m = dyn; day_em = de; one_m = on; one_em = oe;
    end else begin
      sec_m = 0; sec_em = 0; hr_m = 0; hr_em = 0;
      day_m = 0; day_em = 0; one_m = 0; one_em = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sec_ci = 1'b1; sec_dn = 1'b1;
    #2;
    checks++; if ({8'h00, sec_q} !== int2bcd(0)) begin errors++; $display("FAIL rst_q got=%h exp=00", sec_q); end
    checks++; if (sec_co !== 1'b0) begin errors++; $display("FAIL rst_co got=%b exp=0", sec_co); end
    checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", sec_err); end
    tick(); tick();
    checks++; if (sec_q !== 8'h00 || hr_q !== 8'h00) begin errors++; $display("FAIL rst_hold got=%h/%h exp=00/00", sec_q, hr_q); end
    sec_dn = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      $display("reset_count step=%0d q=%h", i, sec_q);
      checks++; if ({8'h00, sec_q} !== int2bcd(sec_m)) begin errors++; $display("FAIL count_up got=%h exp=%0d", sec_q, sec_m); end
    end
    sec_ci = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({8'h00, sec_q} !== int2bcd(sec_m)) begin errors++; $display("FAIL freeze got=%h exp=%0d", sec_q, sec_m); end
    end
  endtask

  task automatic test_up_wrap();
    sec_clr = 1'b1; hr_clr = 1'b1;
    tick();
    sec_clr = 1'b0; hr_clr = 1'b0; sec_ci = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      checks++; if (sec_co !== co_f(sec_m, sec_ci, sec_dn, sec_clr, sec_ld, 60, rst)) begin
        errors++; $display("FAIL up_co q=%h got=%b", sec_q, sec_co); end
      tick();
      checks++; if ({8'h00, sec_q} !== int2bcd(sec_m)) begin errors++; $display("FAIL up_q got=%h exp=%0d", sec_q, sec_m); end
    end
    $display("up_wrap period_end q=%h hr=%h", sec_q, hr_q);
    checks++; if (sec_q !== 8'h00 || hr_q !== 8'h01) begin errors++; $display("FAIL up_period got=%h/%h exp=00/01", sec_q, hr_q); end
    sec_ci = 1'b0;
  endtask

  task automatic test_down_wrap();
    sec_ld = 1'b1; sec_d = 8'h02; sec_dn = 1'b1; sec_ci = 1'b1;
    tick();
    checks++; if (sec_q !== 8'h02) begin errors++; $display("FAIL dn_load got=%h exp=02", sec_q); end
    sec_ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (sec_co !== co_f(sec_m, sec_ci, sec_dn, sec_clr, sec_ld, 60, rst)) begin
        errors++; $display("FAIL dn_co q=%h got=%b", sec_q, sec_co); end
      tick();
      $display("down_wrap step=%0d q=%h", i, sec_q);
      checks++; if ({8'h00, sec_q} !== int2bcd(sec_m)) begin errors++; $display("FAIL dn_q got=%h exp=%0d", sec_q, sec_m); end
    end
    checks++; if (sec_q !== 8'h58) begin errors++; $display("FAIL dn_end got=%h exp=58", sec_q); end
    sec_ci = 1'b0; sec_dn = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] vals [4] = '{8'h23, 8'h24, 8'h1A, 8'h12};
    logic [7:0] expq [4] = '{8'h23, 8'h23, 8'h23, 8'h00};
    bit         expe [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    sec_ci = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hr_ld = 1'b1; hr_d = vals[i]; hr_clr = (i == 3);
      tick();
      $display("load d=%h clr=%b q=%h err=%b", vals[i], hr_clr, hr_q, hr_err);
      checks++; if (hr_q !== expq[i] || {8'h00, hr_q} !== int2bcd(hr_m)) begin
        errors++; $display("FAIL ld_q d=%h got=%h exp=%h", vals[i], hr_q, expq[i]); end
      checks++; if (hr_err !== expe[i] || hr_err !== hr_em) begin
        errors++; $display("FAIL ld_err d=%h got=%b exp=%b", vals[i], hr_err, expe[i]); end
      if (i == 1) begin
        hr_ld = 1'b0;
        tick();
        checks++; if (hr_err !== 1'b0) begin errors++; $display("FAIL err_pulse got=%b exp=0", hr_err); end
      end
    end
    hr_ld = 1'b0; hr_clr = 1'b0;
  endtask

  task automatic test_cascade();
    sec_ld = 1'b1; sec_d = 8'h59; hr_ld = 1'b1; hr_d = 8'h23;
    tick();
    hr_ld = 1'b0; sec_ci = 1'b1; sec_clr = 1'b1;
    #1;
    checks++; if (sec_co !== 1'b0) begin errors++; $display("FAIL co_clr got=%b exp=0", sec_co); end
    sec_clr = 1'b0;
    #1;
    checks++; if (sec_co !== 1'b0) begin errors++; $display("FAIL co_ld got=%b exp=0", sec_co); end
    sec_ld = 1'b0;
    #1;
    checks++; if (sec_co !== 1'b1 || hr_co !== 1'b1) begin errors++; $display("FAIL casc_co got=%b/%b exp=1/1", sec_co, hr_co); end
    tick();
    $display("cascade time=%h:%h", hr_q, sec_q);
    checks++; if (hr_q !== 8'h00 || sec_q !== 8'h00 || {8'h00, hr_q} !== int2bcd(hr_m)) begin
      errors++; $display("FAIL casc_wrap got=%h:%h exp=00:00", hr_q, sec_q); end
    checks++; if (hr_co !== 1'b0) begin errors++; $display("FAIL casc_co_after got=%b exp=0", hr_co); end
    sec_ci = 1'b0;
  endtask

  task automatic test_async_reset();
    sec_ld = 1'b1; sec_d = 8'h37;
    tick();
    sec_d = 8'h6A;
    tick();
    checks++; if (sec_q !== 8'h37 || sec_err !== 1'b1) begin errors++; $display("FAIL pre_rst got=%h/%b exp=37/1", sec_q, sec_err); end
    sec_ld = 1'b0; sec_ci = 1'b1; sec_dn = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    sec_m = 0; sec_em = 0; hr_m = 0; hr_em = 0; day_m = 0; day_em = 0; one_m = 0; one_em = 0;
    $display("async_reset q=%h err=%b co=%b", sec_q, sec_err, sec_co);
    checks++; if (sec_q !== 8'h00 || hr_q !== 8'h00) begin errors++; $display("FAIL async_q got=%h/%h exp=00/00", sec_q, hr_q); end
    checks++; if (sec_err !== 1'b0) begin errors++; $display("FAIL async_err got=%b exp=0", sec_err); end
    checks++; if (sec_co !== 1'b0) begin errors++; $display("FAIL async_co got=%b exp=0", sec_co); end
    sec_dn = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++; if ({8'h00, sec_q} !== int2bcd(i) || sec_m != i) begin errors++; $display("FAIL resume got=%h exp=%0d", sec_q, i); end
    end
    sec_ci = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      day_clr = ($urandom_range(0, 15) == 0);
      day_ld  = ($urandom_range(0, 7) == 0);
      day_ci  = ($urandom_range(0, 3) != 0);
      day_dn  = $urandom_range(0, 1) == 1;
      day_d   = ($urandom_range(0, 1) == 1) ? 12'(int2bcd($urandom_range(0, 420))) : 12'($urandom);
      one_clr = ($urandom_range(0, 15) == 0);
      one_ld  = ($urandom_range(0, 7) == 0);
      one_ci  = ($urandom_range(0, 3) != 0);
      one_dn  = $urandom_range(0, 1) == 1;
      one_d   = 4'($urandom_range(0, 15));
      #1;
      checks++; if (day_co !== co_f(day_m, day_ci, day_dn, day_clr, day_ld, 365, rst)) begin
        errors++; $display("FAIL rnd_day_co n=%0d q=%h got=%b", n, day_q, day_co); end
      checks++; if (one_co !== co_f(one_m, one_ci, one_dn, one_clr, one_ld, 10, rst)) begin
        errors++; $display("FAIL rnd_one_co n=%0d q=%h got=%b", n, one_q, one_co); end
      tick();
      checks++; if ({4'h0, day_q} !== int2bcd(day_m) || day_err !== day_em) begin
        errors++; $display("FAIL rnd_day n=%0d got=%h/%b exp=%0d/%b", n, day_q, day_err, day_m, day_em); end
      checks++; if ({12'h000, one_q} !== int2bcd(one_m) || one_err !== one_em) begin
        errors++; $display("FAIL rnd_one n=%0d got=%h/%b exp=%0d/%b", n, one_q, one_err, one_m, one_em); end
    end
    $display("random done day=%h one=%h", day_q, one_q);
    day_ci = 1'b0; day_ld = 1'b0; day_clr = 1'b0; one_ci = 1'b0; one_ld = 1'b0; one_clr = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    sec_m = 0; hr_m = 0; day_m = 0; one_m = 0;
    sec_em = 0; hr_em = 0; day_em = 0; one_em = 0;
    rst = 1'b0;
    sec_ci = 0; sec_dn = 0; sec_clr = 0; sec_ld = 0; sec_d = '0;
    hr_dn = 0; hr_clr = 0; hr_ld = 0; hr_d = '0;
    day_ci = 0; day_dn = 0; day_clr = 0; day_ld = 0; day_d = '0;
    one_ci = 0; one_dn = 0; one_clr = 0; one_ld = 0; one_d = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_cascade();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
